cpu_timing_sequencer: RTL and testbench
=======================================

// Module: cpu_timing_sequencer
// PURPOSE
// - Timing-signal generator that drives the CPUSystem T[7:0] input; the hardwired control unit consumes T.
// - A 3-bit sequence counter (SC) is decoded to one-hot T; SC advances once per clock.
// - The control unit clears SC at the end of each instruction.
// - Supports hold (stall), halt and resume so the CPU can be frozen or stopped cleanly between instructions.
// PARAMETERS
// - T_WIDTH  8  number of timing phases; power of two, >= 2; width of T
// - SC_W     3  sequence counter width = log2(T_WIDTH)
// PORTS
// - Clock     in   1        system clock; all state changes on posedge
// - Reset     in   1        reset, synchronous, active-low
// - SC_Clear  in   1        control unit request: next phase is T0 (end of instruction)
// - Hold      in   1        stall: keep current SC/T for this cycle
// - Halt      in   1        enter HALTED state (HLT instruction or external stop)
// - Resume    in   1        leave HALTED; restart at T0
// - T         out  T_WIDTH  registered one-hot timing signal to CPUSystem
// - SC        out  SC_W     registered sequence counter value
// - Running   out  1        1 in RUN state, 0 in HALTED
// - FetchPhase out 1        T[0] | T[1]; combinational from registered T
// - WrapErr   out  1        sticky wrap error; port exists only with SEQ_WRAP_ERR_EN
// BEHAVIOUR
// - Reset:
//   - Reset==0 at a posedge overrides all other inputs.
//   - Results: SC=0, T=1 (T0), state RUN, Running=1, WrapErr=0.
//   - Asserting Reset mid-instruction returns to T0 on that same edge.
// - States: RUN, HALTED. Next state and outputs are all registered.
// - RUN, priority per posedge (highest first):
//   1. Halt -> HALTED, SC=0, T=0, Running=0.
//   2. SC_Clear -> SC=0, T=T0. SC_Clear wins over Hold.
//   3. Hold -> SC and T unchanged.
//   4. Otherwise SC=SC+1 mod T_WIDTH, T=1<<SC_next.
// - Wrap-around: SC==T_WIDTH-1 with no clear, hold or halt -> SC=0, T=T0.
//   - This wrap is an unexpected event; with the macro it sets WrapErr.
// - HALTED:
//   - T=0, SC=0, Running=0. Hold and SC_Clear are ignored.
//   - Resume=1 with Halt=0 -> RUN, T=T0, SC=0 on the next edge.
//   - Resume and Halt both 1 -> stay HALTED (Halt dominates).
// - Latency: any input sampled at edge n is reflected on T/SC/Running immediately after edge n.
//   - Example: SC_Clear high during T5 -> T0 in the following cycle.
// - Invariant in RUN: T == (1 << SC), exactly one bit set.
// - FetchPhase is 0 in HALTED because T=0.
// - Inputs are synchronous to Clock; no internal synchronisers.
// CONFIGURATION
// - Macro SEQ_WRAP_ERR_EN.
// - Defined:
//   - WrapErr port and sticky flag are present.
//   - Set on the edge where SC wraps from T_WIDTH-1 to 0 without SC_Clear.
//   - Cleared only by Reset. Halt, Resume and SC_Clear do not clear it.
// - Undefined:
//   - No WrapErr port or register.
//   - Wrap-around behaviour is identical otherwise.
// TESTING
// - Reset low for 2 edges, then high -> T=8'b00000001, SC=0, Running=1; then T=02,04,08 on successive edges.
// - Free-run 8 cycles from T0 -> T7 then T0 on the 9th edge; WrapErr=1 with macro, port absent without.
// - SC_Clear=1 with Hold=1 while T=8'h20 (SC=5) -> next T=8'h01, SC=0.
//   - Hold=1 alone at T=8'h04 for 3 edges -> T stays 8'h04.
// - Halt at T=8'h08 -> T=0, Running=0, FetchPhase=0.
//   - Halt+Resume together -> still halted.
//   - Resume alone -> T=8'h01, Running=1, FetchPhase=1.
// - Reset low while T=8'h40 and WrapErr=1 -> T=8'h01, SC=0, WrapErr=0 after that edge.
// - Random Hold/SC_Clear/Halt/Resume for 1000 cycles -> in RUN, T==(1<<SC) with popcount 1; in HALTED, T==0.

Source files
------------

// File: rtl/cpu_timing_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_timing_sequencer
// Description : Timing-signal generator for the hardwired control unit.
//               A sequence counter (SC) is advanced once per clock and
//               decoded into a registered one-hot timing vector T.  The
//               control unit can clear SC at the end of an instruction,
//               stall the sequence (Hold), stop the CPU (Halt) and restart
//               it at T0 (Resume).
//               Optional feature macro: SEQ_WRAP_ERR_EN adds a sticky
//               WrapErr output that flags an SC wrap without SC_Clear.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_timing_sequencer #(
    parameter int T_WIDTH = 8,
    parameter int SC_W    = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               SC_Clear,
    input  logic               Hold,
    input  logic               Halt,
    input  logic               Resume,
    output logic [T_WIDTH-1:0] T,
    output logic [SC_W-1:0]    SC,
    output logic               Running,
    output logic               FetchPhase
`ifdef SEQ_WRAP_ERR_EN
    ,
    output logic               WrapErr
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [0:0]         ST_RUN    = 1'b0;
    localparam logic [0:0]         ST_HALTED = 1'b1;

    localparam logic [T_WIDTH-1:0] T_ZERO    = '0;
    localparam logic [T_WIDTH-1:0] T_PHASE0  = {{(T_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SC_W-1:0]    SC_ZERO   = '0;
    localparam logic [SC_W-1:0]    SC_ONE    = {{(SC_W-1){1'b0}}, 1'b1};
    localparam logic [SC_W-1:0]    SC_LAST   = SC_W'(T_WIDTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]         state_q,   state_d;
    logic [SC_W-1:0]    sc_q,      sc_d;
    logic [T_WIDTH-1:0] t_q,       t_d;
    logic               running_q, running_d;

    // Free-running increment; SC_W bits wrap naturally because T_WIDTH is
    // a power of two, so SC_LAST + 1 lands on zero.
    logic [SC_W-1:0]    w_sc_inc;
    logic [T_WIDTH-1:0] w_t_inc;
    logic               w_wrap;

    // Increment path shared by the RUN advance case.
    always_comb begin
        w_sc_inc = sc_q + SC_ONE;
        w_t_inc  = T_PHASE0 << w_sc_inc;
    end

    // Next-state logic: RUN priority is Halt > SC_Clear > Hold > advance;
    // in HALTED only Resume (without Halt) does anything.
    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        t_d       = t_q;
        running_d = running_q;
        w_wrap    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (Halt) begin
                    state_d   = ST_HALTED;
                    sc_d      = SC_ZERO;
                    t_d       = T_ZERO;
                    running_d = 1'b0;
                end else if (SC_Clear) begin
                    sc_d      = SC_ZERO;
                    t_d       = T_PHASE0;
                end else if (Hold) begin
                    sc_d      = sc_q;
                    t_d       = t_q;
                end else begin
                    sc_d      = w_sc_inc;
                    t_d       = w_t_inc;
                    // Falling off the last phase means the control unit
                    // never ended the instruction.
                    w_wrap    = (sc_q == SC_LAST);
                end
            end

            ST_HALTED: begin
                sc_d      = SC_ZERO;
                t_d       = T_ZERO;
                running_d = 1'b0;
                if (Resume && !Halt) begin
                    state_d   = ST_RUN;
                    t_d       = T_PHASE0;
                    running_d = 1'b1;
                end
            end

            default: begin
                state_d   = ST_RUN;
                sc_d      = SC_ZERO;
                t_d       = T_PHASE0;
                running_d = 1'b1;
            end
        endcase
    end

    // Registered state; active-low synchronous reset restarts at T0.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= ST_RUN;
            sc_q      <= SC_ZERO;
            t_q       <= T_PHASE0;
            running_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            sc_q      <= sc_d;
            t_q       <= t_d;
            running_q <= running_d;
        end
    end

`ifdef SEQ_WRAP_ERR_EN
    logic wrap_err_q, wrap_err_d;

    // Sticky wrap flag; only Reset clears it.
    always_comb begin
        wrap_err_d = wrap_err_q | w_wrap;
    end

    // Wrap flag register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wrap_err_q <= 1'b0;
        end else begin
            wrap_err_q <= wrap_err_d;
        end
    end

    assign WrapErr = wrap_err_q;
`else
    // Wrap detection still exists structurally but has no observer.
    logic w_wrap_unused;
    assign w_wrap_unused = w_wrap;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign T          = t_q;
    assign SC         = sc_q;
    assign Running    = running_q;
    assign FetchPhase = t_q[0] | t_q[1];

endmodule
`default_nettype wire

// File: tb/tb_cpu_timing_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_timing_sequencer
// Description : Directed and randomised self-checking bench for
//               cpu_timing_sequencer (T_WIDTH=8, SC_W=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_timing_sequencer;

    localparam int T_WIDTH = 8;
    localparam int SC_W    = 3;

    logic               Clock;
    logic               Reset;
    logic               SC_Clear;
    logic               Hold;
    logic               Halt;
    logic               Resume;
    logic [T_WIDTH-1:0] T;
    logic [SC_W-1:0]    SC;
    logic               Running;
    logic               FetchPhase;
`ifdef SEQ_WRAP_ERR_EN
    logic               WrapErr;
`endif

    int n_cmp;
    int n_fail;

    cpu_timing_sequencer #(
        .T_WIDTH (T_WIDTH),
        .SC_W    (SC_W)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .SC_Clear   (SC_Clear),
        .Hold       (Hold),
        .Halt       (Halt),
        .Resume     (Resume),
        .T          (T),
        .SC         (SC),
        .Running    (Running),
        .FetchPhase (FetchPhase)
`ifdef SEQ_WRAP_ERR_EN
        ,
        .WrapErr    (WrapErr)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // One active edge, then settle so outputs can be sampled and inputs changed.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        SC_Clear = 1'b0;
        Hold     = 1'b0;
        Halt     = 1'b0;
        Resume   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b0;
        step();
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b0;
        step();
        step();
        n_cmp++; if (T !== 8'h01) begin n_fail++; $display("FAIL reset_T got %h want %h", T, 8'h01); end
        n_cmp++; if (SC !== 3'd0) begin n_fail++; $display("FAIL reset_SC got %0d want 0", SC); end
        n_cmp++; if (Running !== 1'b1) begin n_fail++; $display("FAIL reset_Running got %b want 1", Running); end
        n_cmp++; if (FetchPhase !== 1'b1) begin n_fail++; $display("FAIL reset_Fetch got %b want 1", FetchPhase); end
`ifdef SEQ_WRAP_ERR_EN
        n_cmp++; if (WrapErr !== 1'b0) begin n_fail++; $display("FAIL reset_WrapErr got %b want 0", WrapErr); end
`endif
        Reset = 1'b1;
        step();
        n_cmp++; if (T !== 8'h02) begin n_fail++; $display("FAIL post_reset_T1 got %h want %h", T, 8'h02); end
        step();
        n_cmp++; if (T !== 8'h04) begin n_fail++; $display("FAIL post_reset_T2 got %h want %h", T, 8'h04); end
        n_cmp++; if (FetchPhase !== 1'b0) begin n_fail++; $display("FAIL post_reset_Fetch got %b want 0", FetchPhase); end
        step();
        n_cmp++; if (T !== 8'h08) begin n_fail++; $display("FAIL post_reset_T3 got %h want %h", T, 8'h08); end
        n_cmp++; if (SC !== 3'd3) begin n_fail++; $display("FAIL post_reset_SC got %0d want 3", SC); end
    endtask

    task automatic test_free_run();
        logic [7:0] exp_t;
        do_reset();
        for (int i = 1; i < 8; i++) begin
            step();
            exp_t = 8'h01 << i;
            n_cmp++; if (T !== exp_t) begin n_fail++; $display("FAIL freerun_T[%0d] got %h want %h", i, T, exp_t); end
            n_cmp++; if (SC !== 3'(i)) begin n_fail++; $display("FAIL freerun_SC[%0d] got %0d want %0d", i, SC, i); end
`ifdef SEQ_WRAP_ERR_EN
            n_cmp++; if (WrapErr !== 1'b0) begin n_fail++; $display("FAIL freerun_WrapErr_early[%0d] got %b want 0", i, WrapErr); end
`endif
        end
        step();
        n_cmp++; if (T !== 8'h01) begin n_fail++; $display("FAIL wrap_T got %h want %h", T, 8'h01); end
        n_cmp++; if (SC !== 3'd0) begin n_fail++; $display("FAIL wrap_SC got %0d want 0", SC); end
`ifdef SEQ_WRAP_ERR_EN
        n_cmp++; if (WrapErr !== 1'b1) begin n_fail++; $display("FAIL wrap_WrapErr got %b want 1", WrapErr); end
`endif
    endtask

    task automatic test_clear_hold();
        do_reset();
        repeat (5) step();
        n_cmp++; if (T !== 8'h20) begin n_fail++; $display("FAIL pre_clear_T got %h want %h", T, 8'h20); end
        SC_Clear = 1'b1;
        Hold     = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (T !== 8'h01) begin n_fail++; $display("FAIL clear_over_hold_T got %h want %h", T, 8'h01); end
        n_cmp++; if (SC !== 3'd0) begin n_fail++; $display("FAIL clear_over_hold_SC got %0d want 0", SC); end
`ifdef SEQ_WRAP_ERR_EN
        n_cmp++; if (WrapErr !== 1'b0) begin n_fail++; $display("FAIL clear_no_wrap got %b want 0", WrapErr); end
`endif
        repeat (2) step();
        n_cmp++; if (T !== 8'h04) begin n_fail++; $display("FAIL pre_hold_T got %h want %h", T, 8'h04); end
        Hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (T !== 8'h04) begin n_fail++; $display("FAIL hold_T[%0d] got %h want %h", i, T, 8'h04); end
            n_cmp++; if (SC !== 3'd2) begin n_fail++; $display("FAIL hold_SC[%0d] got %0d want 2", i, SC); end
        end
        Hold = 1'b0;
        step();
        n_cmp++; if (T !== 8'h08) begin n_fail++; $display("FAIL after_hold_T got %h want %h", T, 8'h08); end
        // Clear from a later phase without hold.
        repeat (3) step();
        n_cmp++; if (T !== 8'h40) begin n_fail++; $display("FAIL pre_clear2_T got %h want %h", T, 8'h40); end
        SC_Clear = 1'b1;
        step();
        SC_Clear = 1'b0;
        n_cmp++; if (T !== 8'h01) begin n_fail++; $display("FAIL clear2_T got %h want %h", T, 8'h01); end
    endtask

    task automatic test_halt_resume();
        do_reset();
        repeat (3) step();
        n_cmp++; if (T !== 8'h08) begin n_fail++; $display("FAIL pre_halt_T got %h want %h", T, 8'h08); end
        Halt = 1'b1;
        step();
        Halt = 1'b0;
        n_cmp++; if (T !== 8'h00) begin n_fail++; $display("FAIL halt_T got %h want 00", T); end
        n_cmp++; if (SC !== 3'd0) begin n_fail++; $display("FAIL halt_SC got %0d want 0", SC); end
        n_cmp++; if (Running !== 1'b0) begin n_fail++; $display("FAIL halt_Running got %b want 0", Running); end
        n_cmp++; if (FetchPhase !== 1'b0) begin n_fail++; $display("FAIL halt_Fetch got %b want 0", FetchPhase); end
        SC_Clear = 1'b1;
        Hold     = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (T !== 8'h00 || Running !== 1'b0) begin n_fail++; $display("FAIL halted_ignores_T got %h/%b want 00/0", T, Running); end
        Halt   = 1'b1;
        Resume = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (Running !== 1'b0) begin n_fail++; $display("FAIL halt_dominates_Running got %b want 0", Running); end
        n_cmp++; if (T !== 8'h00) begin n_fail++; $display("FAIL halt_dominates_T got %h want 00", T); end
        step();
        n_cmp++; if (Running !== 1'b0) begin n_fail++; $display("FAIL stay_halted got %b want 0", Running); end
        Resume = 1'b1;
        step();
        Resume = 1'b0;
        n_cmp++; if (T !== 8'h01) begin n_fail++; $display("FAIL resume_T got %h want %h", T, 8'h01); end
        n_cmp++; if (Running !== 1'b1) begin n_fail++; $display("FAIL resume_Running got %b want 1", Running); end
        n_cmp++; if (FetchPhase !== 1'b1) begin n_fail++; $display("FAIL resume_Fetch got %b want 1", FetchPhase); end
        step();
        n_cmp++; if (T !== 8'h02 || FetchPhase !== 1'b1) begin n_fail++; $display("FAIL resume_next got %h/%b want 02/1", T, FetchPhase); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (14) step();   // wrap once, then six phases into T6
        n_cmp++; if (T !== 8'h40) begin n_fail++; $display("FAIL pre_reset_mid_T got %h want %h", T, 8'h40); end
`ifdef SEQ_WRAP_ERR_EN
        n_cmp++; if (WrapErr !== 1'b1) begin n_fail++; $display("FAIL pre_reset_mid_WrapErr got %b want 1", WrapErr); end
        Halt = 1'b1;
        step();
        Halt   = 1'b0;
        Resume = 1'b1;
        step();
        Resume = 1'b0;
        n_cmp++; if (WrapErr !== 1'b1) begin n_fail++; $display("FAIL wraperr_sticky got %b want 1", WrapErr); end
        repeat (6) step();
`endif
        Reset = 1'b0;
        Hold  = 1'b1;
        Halt  = 1'b1;
        step();
        Reset = 1'b1;
        idle_inputs();
        n_cmp++; if (T !== 8'h01) begin n_fail++; $display("FAIL reset_mid_T got %h want %h", T, 8'h01); end
        n_cmp++; if (SC !== 3'd0) begin n_fail++; $display("FAIL reset_mid_SC got %0d want 0", SC); end
        n_cmp++; if (Running !== 1'b1) begin n_fail++; $display("FAIL reset_mid_Running got %b want 1", Running); end
`ifdef SEQ_WRAP_ERR_EN
        n_cmp++; if (WrapErr !== 1'b0) begin n_fail++; $display("FAIL reset_mid_WrapErr got %b want 0", WrapErr); end
`endif
    endtask

    task automatic test_random();
        logic       m_halted;
        logic [2:0] m_sc;
        logic       m_wrap;
        logic [7:0] exp_t;
        do_reset();
        m_halted = 1'b0;
        m_sc     = 3'd0;
        m_wrap   = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            Halt     = ($urandom_range(0, 9) == 0);
            Resume   = ($urandom_range(0, 3) == 0);
            SC_Clear = ($urandom_range(0, 5) == 0);
            Hold     = ($urandom_range(0, 3) == 0);
            if (!m_halted) begin
                if (Halt) begin
                    m_halted = 1'b1;
                    m_sc     = 3'd0;
                end else if (SC_Clear) begin
                    m_sc = 3'd0;
                end else if (!Hold) begin
                    if (m_sc == 3'd7) m_wrap = 1'b1;
                    m_sc = m_sc + 3'd1;
                end
            end else if (Resume && !Halt) begin
                m_halted = 1'b0;
                m_sc     = 3'd0;
            end
            step();
            exp_t = m_halted ? 8'h00 : (8'h01 << m_sc);
            n_cmp++;
            if (T !== exp_t || SC !== m_sc || Running !== !m_halted ||
                $countones(T) != (m_halted ? 0 : 1)) begin
                n_fail++;
                $display("FAIL random[%0d] got T=%h SC=%0d Run=%b want T=%h SC=%0d Run=%b",
                         i, T, SC, Running, exp_t, m_sc, !m_halted);
            end
`ifdef SEQ_WRAP_ERR_EN
            n_cmp++; if (WrapErr !== m_wrap) begin n_fail++; $display("FAIL random_WrapErr[%0d] got %b want %b", i, WrapErr, m_wrap); end
`else
            m_wrap = 1'b0;
`endif
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        Reset  = 1'b0;
        idle_inputs();
        #2;
        test_reset();
        test_free_run();
        test_clear_hold();
        test_halt_resume();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
